// File: rtl/hs_ifr_byte2word_packer.sv
// Byte-to-word packer: assembles lg_byte_t beats into lg_word_t beats with
// per-byte keep, a last flag and an optional idle-timeout flush.

package hs_ifr_int_typedefs_pkg;
  typedef logic [7:0]  lg_byte_t;
  typedef logic [31:0] lg_word_t;
endpackage

module hs_ifr_byte2word_packer
  import hs_ifr_int_typedefs_pkg::*;
#(
  parameter bit          BIG_ENDIAN    = 1'b0,
  parameter int unsigned FLUSH_TIMEOUT = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  lg_byte_t   s_data_i,
  input  logic       s_last_i,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output lg_word_t   m_data_o,
  output logic [3:0] m_keep_o,
  output logic       m_last_o,
  output logic       busy_o
);

  localparam logic [16:0] FT         = 17'(FLUSH_TIMEOUT);
  localparam bit          TIMEOUT_EN = (FLUSH_TIMEOUT != 0);

  // Both ports: a beat moves on a cycle where valid && ready; valid never
  // depends on ready, and m_* stays stable from m_valid_o until m_ready_i.

  logic [1:0]  cnt;
  lg_word_t    asm_buf;
  logic [15:0] timer;

  logic        out_free;
  logic        in_hs;
  logic        completing;
  logic        timer_hit;
  logic        flush;
  logic [1:0]  lane;
  lg_word_t    merged;

  logic [1:0]  cnt_n;
  lg_word_t    buf_n;
  logic [15:0] timer_n;
  logic        mv_n;
  lg_word_t    md_n;
  logic [3:0]  mk_n;
  logic        ml_n;

  // Keep is a contiguous mask from the first-arrived lane, whatever the byte order.
  function automatic logic [3:0] keep_for(input logic [2:0] n);
    case (n)
      3'd1:    keep_for = 4'b0001;
      3'd2:    keep_for = 4'b0011;
      3'd3:    keep_for = 4'b0111;
      3'd4:    keep_for = 4'b1111;
      default: keep_for = 4'b0000;
    endcase
  endfunction

  assign out_free   = !m_valid_o || m_ready_i;
  assign s_ready_o  = rst_ni && (((cnt != 2'd3) && !s_last_i) || out_free);
  assign in_hs      = s_valid_i && s_ready_o;
  assign completing = in_hs && ((cnt == 2'd3) || s_last_i);
  assign lane       = BIG_ENDIAN ? (2'd3 - cnt) : cnt;

  // Fires on the idle cycle whose edge would make the count reach the limit.
  assign timer_hit  = TIMEOUT_EN && (({1'b0, timer} + 17'd1) >= FT);
  assign flush      = TIMEOUT_EN && (cnt != 2'd0) && !in_hs && timer_hit && out_free;

  always_comb begin
    merged = asm_buf;
    merged[{lane, 3'b000} +: 8] = s_data_i;
  end

  always_comb begin
    cnt_n   = cnt;
    buf_n   = asm_buf;
    timer_n = timer;
    mv_n    = m_valid_o;
    md_n    = m_data_o;
    mk_n    = m_keep_o;
    ml_n    = m_last_o;

    if (m_valid_o && m_ready_i) begin
      mv_n = 1'b0;
    end

    if (completing) begin
      mv_n  = 1'b1;
      md_n  = merged;
      mk_n  = keep_for({1'b0, cnt} + 3'd1);
      ml_n  = s_last_i;
      cnt_n = 2'd0;
      buf_n = '0;
    end else if (flush) begin
      mv_n  = 1'b1;
      md_n  = asm_buf;
      mk_n  = keep_for({1'b0, cnt});
      ml_n  = 1'b0;
      cnt_n = 2'd0;
      buf_n = '0;
    end else if (in_hs) begin
      buf_n = merged;
      cnt_n = cnt + 2'd1;
    end

    // Saturates at the limit so a flush blocked by backpressure stays pending.
    if (!TIMEOUT_EN || in_hs || (cnt == 2'd0) || flush) begin
      timer_n = '0;
    end else if ({1'b0, timer} < FT) begin
      timer_n = timer + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt       <= '0;
      asm_buf   <= '0;
      timer     <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_keep_o  <= '0;
      m_last_o  <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      asm_buf   <= buf_n;
      timer     <= timer_n;
      m_valid_o <= mv_n;
      m_data_o  <= md_n;
      m_keep_o  <= mk_n;
      m_last_o  <= ml_n;
      busy_o    <= (cnt_n != 2'd0) || mv_n;
    end
  end

endmodule

// File: tb/tb_hs_ifr_byte2word_packer.sv
// Bench for hs_ifr_byte2word_packer: little-endian/timeout instance checked every
// cycle against a byte-queue model, big-endian/no-timeout instance by directed checks.

module tb_hs_ifr_byte2word_packer;

  localparam int FT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        busy;

  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic [7:0]  b_s_data = '0;
  logic        b_s_last = 1'b0;
  logic        b_m_valid;
  logic        b_m_ready = 1'b1;
  logic [31:0] b_m_data;
  logic [3:0]  b_m_keep;
  logic        b_m_last;
  logic        b_busy;

  int checks = 0;
  int failures = 0;

  logic [36:0] obs_q[$];
  logic [36:0] exp_q[$];

  // model state
  logic [7:0]  part[$];
  int          idle = 0;
  logic        mv = 1'b0;
  logic [31:0] mdata = '0;
  logic [3:0]  mkeep = '0;
  logic        mlast = 1'b0;

  hs_ifr_byte2word_packer #(.BIG_ENDIAN(1'b0), .FLUSH_TIMEOUT(FT)) u_le (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_keep_o(m_keep),
    .m_last_o(m_last), .busy_o(busy)
  );

  hs_ifr_byte2word_packer #(.BIG_ENDIAN(1'b1), .FLUSH_TIMEOUT(0)) u_be (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(b_s_valid), .s_ready_o(b_s_ready), .s_data_i(b_s_data), .s_last_i(b_s_last),
    .m_valid_o(b_m_valid), .m_ready_i(b_m_ready), .m_data_o(b_m_data), .m_keep_o(b_m_keep),
    .m_last_o(b_m_last), .busy_o(b_busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  // model: bytes wait in a queue until four arrive, last is seen, or the idle limit hits
  task automatic emit(input logic l);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < part.size(); i++) w[8*i +: 8] = part[i];
    mdata = w;
    mkeep = 4'((1 << part.size()) - 1);
    mlast = l;
    mv    = 1'b1;
    part.delete();
    idle  = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        part.delete();
        idle = 0;
        mv = 1'b0; mdata = '0; mkeep = '0; mlast = 1'b0;
      end else begin
        logic of, rdy, hs;
        of  = !mv || m_ready;
        rdy = ((part.size() != 3) && !s_last) || of;
        hs  = s_valid && rdy;
        if (mv && m_ready) mv = 1'b0;
        if (hs) begin
          part.push_back(s_data);
          idle = 0;
          if (part.size() == 4 || s_last) emit(s_last);
        end else if (part.size() != 0) begin
          idle++;
          if (idle >= FT && of) emit(1'b0);
        end else begin
          idle = 0;
        end
      end
    end
  end

  // compare process
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_m_valid", 64'(m_valid), 64'(mv));
        if (mv) begin
          chk("cyc_m_data", 64'(m_data), 64'(mdata));
          chk("cyc_m_keep", 64'(m_keep), 64'(mkeep));
          chk("cyc_m_last", 64'(m_last), 64'(mlast));
        end
        chk("cyc_busy", 64'(busy), 64'((part.size() != 0) || mv));
        chk("cyc_s_ready", 64'(s_ready),
            64'(((part.size() != 3) && !s_last) || !mv || m_ready));
        if (m_valid && m_ready) obs_q.push_back({m_last, m_keep, m_data});
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] d, input logic l);
    int waited;
    logic acc;
    waited = 0;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'(1));
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int waited;
    logic acc;
    waited = 0;
    acc = 1'b0;
    b_s_valid = 1'b1; b_s_data = d; b_s_last = l;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = b_s_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) chk("send_b_timeout", 64'(acc), 64'(1));
    b_s_valid = 1'b0; b_s_last = 1'b0;
  endtask

  task automatic expect_w(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({l, k, d});
  endtask

  task automatic check_obs(input string name);
    while (exp_q.size() != 0) begin
      if (obs_q.size() == 0) begin
        chk(name, 64'(0), 64'(exp_q.pop_front()));
      end else begin
        chk(name, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      end
    end
    chk({name, "_extra"}, 64'(obs_q.size()), 64'(0));
  endtask

  initial begin
    // reset block
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1; b_s_valid = 1'b1;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_keep", 64'(m_keep), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_b_s_ready", 64'(b_s_ready), 64'(0));
    s_valid = 1'b0; b_s_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full words, little endian
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("full_w0_valid", 64'(m_valid), 64'(1));
    chk("full_w0_data", 64'(m_data), 64'h44332211);
    chk("full_w0_keep", 64'(m_keep), 64'hF);
    chk("full_w0_last", 64'(m_last), 64'(0));
    send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'h88, 1);
    chk("full_w1_data", 64'(m_data), 64'h88776655);
    chk("full_w1_keep", 64'(m_keep), 64'hF);
    chk("full_w1_last", 64'(m_last), 64'(1));
    repeat (2) @(posedge clk); #1;
    obs_q.delete();

    // backpressure: 8th byte stalls until the output register can drain
    m_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(8'(i), 0);
    s_valid = 1'b1; s_data = 8'h08; s_last = 1'b1;
    @(negedge clk);
    chk("bp_stall0", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_stall1", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk); #1;
    expect_w(32'h04030201, 4'hF, 1'b0);
    expect_w(32'h08070605, 4'hF, 1'b1);
    check_obs("bp_order");

    // timeout flush of a single byte
    send(8'h5A, 0);
    repeat (4) @(posedge clk); #1;
    chk("to_before", 64'(m_valid), 64'(0));
    @(posedge clk); #1;
    chk("to_valid", 64'(m_valid), 64'(1));
    chk("to_data", 64'(m_data), 64'h0000005A);
    chk("to_keep", 64'(m_keep), 64'h1);
    chk("to_last", 64'(m_last), 64'(0));
    repeat (2) @(posedge clk); #1;
    obs_q.delete();

    // byte arriving on the 5th idle cycle cancels the flush and restarts the count
    send(8'hA1, 0);
    repeat (4) @(posedge clk); #1;
    send(8'hA2, 0);
    chk("col_noflush", 64'(m_valid), 64'(0));
    repeat (4) @(posedge clk); #1;
    chk("col_before", 64'(m_valid), 64'(0));
    @(posedge clk); #1;
    chk("col_valid", 64'(m_valid), 64'(1));
    chk("col_data", 64'(m_data), 64'h0000A2A1);
    chk("col_keep", 64'(m_keep), 64'h3);
    repeat (2) @(posedge clk); #1;
    obs_q.delete();

    // flush held pending behind a stalled output word
    m_ready = 1'b0;
    send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
    send(8'hD1, 0);
    repeat (8) @(posedge clk); #1;
    chk("pend_hold", 64'(m_data), 64'hC4C3C2C1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("pend_valid", 64'(m_valid), 64'(1));
    chk("pend_data", 64'(m_data), 64'h000000D1);
    chk("pend_keep", 64'(m_keep), 64'h1);
    repeat (2) @(posedge clk); #1;
    obs_q.delete();

    // async reset mid-packet with a held output word
    m_ready = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h05, 0); send(8'h06, 0);
    chk("ar_pre_valid", 64'(m_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("ar_m_valid", 64'(m_valid), 64'(0));
    chk("ar_m_data", 64'(m_data), 64'(0));
    chk("ar_m_keep", 64'(m_keep), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    s_valid = 1'b1;
    chk("ar_s_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ar_no_stale", 64'(m_valid), 64'(0));
    end
    chk("ar_obs_empty", 64'(obs_q.size()), 64'(0));
    send(8'hE1, 0); send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
    repeat (2) @(posedge clk); #1;
    expect_w(32'hE4E3E2E1, 4'hF, 1'b0);
    check_obs("ar_clean");

    // big-endian partial last, then a full word proves the lane counter restarted
    send_b(8'hAA, 0); send_b(8'hBB, 1);
    chk("be_valid", 64'(b_m_valid), 64'(1));
    chk("be_data", 64'(b_m_data), 64'hAABB0000);
    chk("be_keep", 64'(b_m_keep), 64'h3);
    chk("be_last", 64'(b_m_last), 64'(1));
    send_b(8'h11, 0); send_b(8'h22, 0); send_b(8'h33, 0); send_b(8'h44, 0);
    chk("be_full_data", 64'(b_m_data), 64'h11223344);
    chk("be_full_keep", 64'(b_m_keep), 64'hF);
    chk("be_full_last", 64'(b_m_last), 64'(0));

    // without a timeout a partial word waits for last
    send_b(8'hCC, 0);
    repeat (20) @(posedge clk); #1;
    chk("be_nto_valid", 64'(b_m_valid), 64'(0));
    chk("be_nto_busy", 64'(b_busy), 64'(1));
    send_b(8'hDD, 1);
    chk("be_nto_data", 64'(b_m_data), 64'hCCDD0000);
    chk("be_nto_keep", 64'(b_m_keep), 64'h3);
    chk("be_nto_last", 64'(b_m_last), 64'(1));
    repeat (2) @(posedge clk); #1;
    chk("be_idle_busy", 64'(b_busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_ifr_byte2word_packer.md
Name: hs_ifr_byte2word_packer

Overview:
Byte-stream to word-stream packer. It accepts lg_byte_t beats on a valid/ready interface and assembles them into lg_word_t beats with per-byte keep and a last flag. It sits downstream of byte-wide sources such as the UART RX or SPI slave. It sits upstream of word-wide consumers such as the bus-bridge write FIFO. Types come from hs_ifr_int_typedefs_pkg: lg_byte_t is 8b and lg_word_t is 32b.

Parameters:
BIG_ENDIAN, 0, 0 places the first byte in word[7:0]; 1 places it in word[31:24].
FLUSH_TIMEOUT, 0, idle cycles before a partial word is flushed; 0 disables the timeout (range 0..65535).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  Asynchronous active-low reset.
s_valid_i  in  1  input byte valid.
s_ready_o  out  1  input byte ready.
s_data_i  in  8  input byte (lg_byte_t).
s_last_i  in  1  marks the last byte of a packet.
m_valid_o  out  1  output word valid.
m_ready_i  in  1  output word ready.
m_data_o  out  32  output word (lg_word_t).
m_keep_o  out  4  byte-valid mask, one bit per byte lane.
m_last_o  out  1  marks the last word of a packet.
busy_o  out  1  high while the assembly buffer holds at least one byte, or the output register is valid.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low.
- Reset values: m_valid_o=0, m_data_o=0, m_keep_o=0, m_last_o=0, busy_o=0. Lane counter=0, assembly buffer=0, timeout counter=0.
- s_ready_o is 0 while rst_ni is low.
- Storage: a 4-byte assembly buffer, a 2-bit lane counter, and one output register stage.
- Transfer rule: a transfer occurs on either port on a cycle where valid&&ready. valid must not depend on ready. Once asserted, m_valid_o and the m_* payload are held until m_ready_i.
- Input accept: the byte is written to lane[cnt]. Lane position follows BIG_ENDIAN. cnt then increments.
- Completing beat: the accepted byte is a completing beat if cnt==3 or s_last_i=1.
- On a completing beat, the assembled word moves to the output register in the same edge:
  - keep = (1<<(cnt+1))-1 in lane order, so it is contiguous from the first lane.
  - Unused lanes are 0.
  - last = s_last_i.
  - cnt returns to 0.
- s_ready_o when the next beat would not complete: 1, because the assembly buffer has room.
- s_ready_o when the next beat would complete: it must have s_ready_o = !m_valid_o || m_ready_i. This is a combinational path from m_ready_i, which is accepted.
- Since completion depends on s_last_i, s_ready_o = (cnt!=3 && !s_last_i) || !m_valid_o || m_ready_i.
- Throughput: 1 byte/cycle sustained. Latency is 1 cycle from the completing byte to m_valid_o.
- Output register: cleared (m_valid_o=0) on an output handshake with no new completion. It is loaded on completion. Simultaneous drain and load leaves m_valid_o=1 with the new payload.
- Timeout flush (FLUSH_TIMEOUT>0):
  - A 16b counter increments each cycle while cnt!=0 and no input handshake occurs.
  - It resets on any input handshake or when cnt==0.
  - On reaching FLUSH_TIMEOUT with the output register free (!m_valid_o || m_ready_i), the partial word is emitted with keep for cnt bytes and last=0. cnt returns to 0.
  - If the output register is not free, the flush is held pending and the counter saturates.
  - An input handshake in the same cycle as a timeout flush takes priority: the byte is appended and the flush is cancelled.
- FLUSH_TIMEOUT=0: partial words leave only on s_last_i.
- busy_o = (cnt!=0) || m_valid_o, registered.
- Reset mid-packet discards the partial word and any pending output with no output beat.

Test Plan:
- Full words, BIG_ENDIAN=0, m_ready_i=1: bytes 11,22,33,44,55,66,77,88 with last on 88 give word 0x44332211 keep 0xF last 0, then 0x88776655 keep 0xF last 1. The first word is valid the cycle after 44 is accepted.
- Partial last, BIG_ENDIAN=1: bytes AA,BB with last on BB give word 0xAABB0000 keep 0b0011 (lane-order mask) last 1. cnt then reads 0.
- Backpressure: m_ready_i=0 with 8 bytes offered gives s_ready_o low on the 8th byte after accepting 7. No data loss. Raising m_ready_i accepts the 8th byte that cycle, and both words drain in order.
- Timeout, FLUSH_TIMEOUT=5: byte 0x5A then idle gives word 0x0000005A keep 0x1 last 0 on m_valid_o exactly 5 idle cycles later.
- Timeout collision: a byte accepted on the 5th idle cycle means no flush occurs. cnt=2 and the timeout counter clears.
- Async reset: assert rst_ni low after 2 bytes with m_valid_o=1 held. All outputs go 0 immediately. After release, no stale beat appears, and the next 4 bytes form a clean word.
